// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller:
// FSM state encoding and operand-forward select codes.
package hazard_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } hz_state_e;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_M  = 2'b10;
    localparam logic [1:0] FWD_W  = 2'b01;

endpackage

// File: rtl/fwd_sel.sv
// Operand forward selector for one Execute source register.
// Memory-stage result has priority over Writeback; x0 is never forwarded.
module fwd_sel
    import hazard_pkg::*;
(
    input  logic [4:0] rs_i,
    input  logic [4:0] rdM_i,
    input  logic       RegWriteM_i,
    input  logic [4:0] rdW_i,
    input  logic       RegWriteW_i,
    output logic [1:0] fwd_o
);

    // Priority compare: M over W over register file.
    always_comb begin
        fwd_o = FWD_RF;
        if (RegWriteM_i && (rdM_i != 5'd0) && (rdM_i == rs_i)) begin
            fwd_o = FWD_M;
        end else if (RegWriteW_i && (rdW_i != 5'd0) && (rdW_i == rs_i)) begin
            fwd_o = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32 pipeline: forwarding selects,
// load-use bubbles, branch flushes and memory-wait freeze with a watchdog.
// Optional macro HAZ_PERF_EN adds stall_cnt / flush_cnt performance counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 16,
    parameter int unsigned CNT_W    = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs1D,
    input  logic [4:0]  rs2D,
    input  logic [4:0]  rs1E,
    input  logic [4:0]  rs2E,
    input  logic [4:0]  rdE,
    input  logic        MemtoRegE,
    input  logic [4:0]  rdM,
    input  logic        RegWriteM,
    input  logic [4:0]  rdW,
    input  logic        RegWriteW,
    input  logic        PCSrcE,
    input  logic        dmem_req,
    input  logic        dmem_ack,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushW,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        mem_err,
    output logic        busy
`ifdef HAZ_PERF_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    hz_state_e        state_q, state_d;
    logic [CNT_W-1:0] wd_q, wd_d;
    logic             err_q, err_d;
    logic             lu;
    logic             hold;

    fwd_sel u_fwd_a (
        .rs_i        (rs1E),
        .rdM_i       (rdM),
        .RegWriteM_i (RegWriteM),
        .rdW_i       (rdW),
        .RegWriteW_i (RegWriteW),
        .fwd_o       (ForwardAE)
    );

    fwd_sel u_fwd_b (
        .rs_i        (rs2E),
        .rdM_i       (rdM),
        .RegWriteM_i (RegWriteM),
        .rdW_i       (rdW),
        .RegWriteW_i (RegWriteW),
        .fwd_o       (ForwardBE)
    );

    assign lu = MemtoRegE && (rdE != 5'd0) && ((rdE == rs1D) || (rdE == rs2D));

    // Next-state, watchdog and control decode; memory freeze overrides
    // branch flush, which in turn overrides the load-use bubble.
    always_comb begin
        state_d = state_q;
        wd_d    = wd_q;
        err_d   = err_q;
        hold    = 1'b0;
        FlushD  = 1'b0;
        FlushE  = 1'b0;
        StallF  = 1'b0;
        StallD  = 1'b0;
        unique case (state_q)
            RUN: begin
                if (dmem_req && !dmem_ack) begin
                    hold    = 1'b1;
                    wd_d    = CNT_W'(1);
                    state_d = WAIT;
                end else if (PCSrcE) begin
                    FlushD = 1'b1;
                    FlushE = 1'b1;
                end else if (lu) begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    FlushE = 1'b1;
                end
            end
            WAIT: begin
                if (dmem_ack) begin
                    wd_d    = '0;
                    state_d = RUN;
                end else begin
                    hold = 1'b1;
                    if (wd_q == CNT_W'(MAX_WAIT)) begin
                        err_d   = 1'b1;
                        wd_d    = '0;
                        state_d = RUN;
                    end else if (wd_q != '1) begin
                        wd_d = wd_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = RUN;
                wd_d    = '0;
            end
        endcase
        if (hold) begin
            StallF = 1'b1;
            StallD = 1'b1;
        end
    end

    assign StallE  = hold;
    assign StallM  = hold;
    assign FlushW  = hold;
    assign busy    = (state_q == WAIT);
    assign mem_err = err_q;

    // State, watchdog and sticky error registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            wd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
        end
    end

`ifdef HAZ_PERF_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    // Free-running performance counters, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (StallF) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (FlushD) flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl (MAX_WAIT = 4): directed scenarios
// followed by randomized traffic, all checked against a behavioural model.
module tb_hazard_ctrl;

    localparam int MAXW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic       MemtoRegE, RegWriteM, RegWriteW, PCSrcE, dmem_req, dmem_ack;
    logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic [1:0] ForwardAE, ForwardBE;
    logic       mem_err, busy;
`ifdef HAZ_PERF_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    hazard_ctrl #(.MAX_WAIT(MAXW), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
        .rdE(rdE), .MemtoRegE(MemtoRegE),
        .rdM(rdM), .RegWriteM(RegWriteM),
        .rdW(rdW), .RegWriteW(RegWriteW),
        .PCSrcE(PCSrcE), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .mem_err(mem_err), .busy(busy)
`ifdef HAZ_PERF_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: "waiting" flag, cycles spent waiting, sticky error.
    bit          m_wait = 1'b0;
    int          m_waited = 0;
    bit          m_err = 1'b0;
    int unsigned m_stalls = 0;
    int unsigned m_flushes = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (RegWriteM && rdM != 0 && rdM == rs) return 2'b10;
        if (RegWriteW && rdW != 0 && rdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit ref_lu();
        return MemtoRegE && rdE != 0 && (rdE == rs1D || rdE == rs2D);
    endfunction

    function automatic bit ref_hold();
        return m_wait ? !dmem_ack : (dmem_req && !dmem_ack);
    endfunction

    function automatic bit ref_stallF();
        return ref_hold() || (!m_wait && !PCSrcE && ref_lu());
    endfunction

    function automatic bit ref_flushD();
        return !m_wait && !ref_hold() && PCSrcE;
    endfunction

    task automatic check_all();
        bit h;
        h = ref_hold();
        chk("StallF", StallF, ref_stallF());
        chk("StallD", StallD, ref_stallF());
        chk("StallE", StallE, h);
        chk("StallM", StallM, h);
        chk("FlushW", FlushW, h);
        chk("FlushD", FlushD, ref_flushD());
        chk("FlushE", FlushE, !m_wait && !h && (PCSrcE || ref_lu()));
        chk("ForwardAE", ForwardAE, ref_fwd(rs1E));
        chk("ForwardBE", ForwardBE, ref_fwd(rs2E));
        chk("busy", busy, m_wait);
        chk("mem_err", mem_err, m_err);
`ifdef HAZ_PERF_EN
        chk("stall_cnt", stall_cnt, m_stalls);
        chk("flush_cnt", flush_cnt, m_flushes);
`endif
    endtask

    // One clock cycle: optionally check outputs, then advance the model.
    task automatic tick(input bit do_chk);
        bit sf, fd;
        #2;
        if (do_chk) check_all();
        sf = ref_stallF();
        fd = ref_flushD();
        @(posedge clk);
        if (rst) begin
            m_wait = 0; m_waited = 0; m_err = 0; m_stalls = 0; m_flushes = 0;
        end else begin
            if (sf) m_stalls++;
            if (fd) m_flushes++;
            if (!m_wait) begin
                if (dmem_req && !dmem_ack) begin
                    m_wait = 1; m_waited = 1;
                end
            end else if (dmem_ack) begin
                m_wait = 0; m_waited = 0;
            end else if (m_waited >= MAXW) begin
                m_wait = 0; m_waited = 0; m_err = 1;
            end else begin
                m_waited++;
            end
        end
        #1;
    endtask

    task automatic idle();
        rs1D = 0; rs2D = 0; rs1E = 0; rs2E = 0; rdE = 0; rdM = 0; rdW = 0;
        MemtoRegE = 0; RegWriteM = 0; RegWriteW = 0; PCSrcE = 0;
        dmem_req = 0; dmem_ack = 0;
    endtask

    initial begin
        idle();
        rst = 1;
        tick(0);
        tick(1);
        rst = 0;
        // Reset state with idle inputs.
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_err", mem_err, 0);
        chk("rst_stallF", StallF, 0);
        chk("rst_fwdA", ForwardAE, 2'b00);
        tick(1);

        // M forwarding priority, then W when rdM = x0.
        rs1E = 5; rdM = 5; RegWriteM = 1; rdW = 5; RegWriteW = 1;
        #1; chk("fwdA_M", ForwardAE, 2'b10);
        tick(1);
        rdM = 0;
        #1; chk("fwdA_W", ForwardAE, 2'b01);
        tick(1);
        idle();

        // Load-use: one bubble, then pipeline has moved on.
        MemtoRegE = 1; rdE = 7; rs2D = 7;
        #1; chk("lu_stallF", StallF, 1); chk("lu_flushE", FlushE, 1);
        tick(1);
        MemtoRegE = 0; rdE = 0; rs2D = 3;
        #1; chk("lu_after", StallF, 0);
        tick(1);
        MemtoRegE = 1; rdE = 0; rs2D = 0;
        #1; chk("lu_x0", StallD, 0);
        tick(1);

        // Branch wins over load-use.
        MemtoRegE = 1; rdE = 9; rs1D = 9; PCSrcE = 1;
        #1; chk("br_flushD", FlushD, 1); chk("br_stallF", StallF, 0);
        tick(1);
        idle();

        // Memory wait: 3 cycles without ack, ack on the 4th.
        dmem_req = 1; PCSrcE = 1;
        #1; chk("mw1_stallM", StallM, 1); chk("mw1_flushD", FlushD, 0);
        tick(1);
        #1; chk("mw2_busy", busy, 1);
        tick(1);
        tick(1);
        dmem_ack = 1;
        #1; chk("mw4_stallE", StallE, 0);
        tick(1);
        idle();
        #1; chk("mw_run", busy, 0);
        tick(1);

        // Watchdog: ack never arrives.
        dmem_req = 1;
        for (int i = 0; i < 1 + MAXW; i++) tick(1);
        dmem_req = 0;
        #1; chk("wd_err", mem_err, 1); chk("wd_busy", busy, 0);
        for (int i = 0; i < 3; i++) tick(1);
        #1; chk("wd_sticky", mem_err, 1);

        // Reset while waiting.
        dmem_req = 1;
        tick(1);
        tick(1);
        rst = 1;
        tick(1);
        rst = 0; dmem_req = 0;
        #1;
        chk("rw_busy", busy, 0);
        chk("rw_err", mem_err, 0);
        chk("rw_stallM", StallM, 0);
`ifdef HAZ_PERF_EN
        chk("rw_stall_cnt", stall_cnt, 0);
`endif
        tick(1);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            rst       = ($urandom_range(0, 59) == 0);
            rs1D      = 5'($urandom_range(0, 3));
            rs2D      = 5'($urandom_range(0, 3));
            rs1E      = 5'($urandom_range(0, 3));
            rs2E      = 5'($urandom_range(0, 3));
            rdE       = 5'($urandom_range(0, 3));
            rdM       = 5'($urandom_range(0, 3));
            rdW       = 5'($urandom_range(0, 3));
            MemtoRegE = 1'($urandom_range(0, 1));
            RegWriteM = 1'($urandom_range(0, 1));
            RegWriteW = 1'($urandom_range(0, 1));
            PCSrcE    = ($urandom_range(0, 3) == 0);
            dmem_req  = ($urandom_range(0, 2) == 0);
            dmem_ack  = ($urandom_range(0, 3) == 0);
            tick(1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
